axi_lite_csr_bank: RTL

Parametrised AXI-Lite slave register bank and next-generation control front end for the matrix compute core. It provides a configurable number of config registers, byte-strobed writes, and independent AW/W acceptance. A START command produces a single-cycle pulse, STATUS carries sticky W1C DONE/ERR bits, and a maskable interrupt is driven out. It sits between the AXI-Lite interconnect and the compute core control ports.

---
 rtl/axi_lite_csr_bank_if.sv | 38 +++
 rtl/axi_lite_csr_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_csr_bank_if.sv
// AXI-Lite port bundle between the interconnect and the CSR bank.
// The master drives addresses, data and valids. The slave drives readies and responses.
interface axi_lite_csr_bank_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_csr_bank.sv
// AXI-Lite control/status register bank for the matrix compute core.
// Provides START pulse, sticky W1C DONE/ERR, byte-strobed CFG registers and a maskable irq.
module axi_lite_csr_bank #(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 32,
    parameter int          NUM_CFG = 3,
    parameter logic [31:0] VERSION = 32'h0002_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    axi_lite_csr_bank_if.slave        s_axi,
    input  logic                      core_busy,
    input  logic                      core_done,
    output logic                      start_pulse,
    output logic [NUM_CFG*DATA_W-1:0] cfg_flat,
    output logic                      irq
);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [IDX_W-1:0] IDX_CTRL   = '0;
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ID     = IDX_W'(NUM_CFG + 2);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write-side holding registers
    logic              aw_held;
    logic [IDX_W-1:0]  aw_idx;
    logic              w_held;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              bvalid_q;
    logic [1:0]        bresp_q;

    // Read-side response registers
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;

    // Architectural state
    logic              irq_en;
    logic              done_q;
    logic              err_q;
    logic              start_q;
    logic              irq_q;
    logic [DATA_W-1:0] cfg_q [NUM_CFG];

    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              b_hs;
    logic              r_hs;
    logic              commit;
    logic [IDX_W-1:0]  wa_idx;
    logic [DATA_W-1:0] wd_data;
    logic [STRB_W-1:0] wd_strb;
    logic              wa_map;
    logic              wr_ctrl;
    logic              wr_status;
    logic [NUM_CFG-1:0] wr_cfg;
    logic              start_req;
    logic              start_go;
    logic              start_err;
    logic              clr_done;
    logic              clr_err;

    logic [IDX_W-1:0]  rd_idx;
    logic              rd_cfg_hit;
    logic [DATA_W-1:0] rd_cfg_val;
    logic [DATA_W-1:0] rd_val;
    logic              rd_slverr;

    logic unused_addr_lsbs;

    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    assign s_axi.awready = !rst && !aw_held && !bvalid_q;
    assign s_axi.wready  = !rst && !w_held && !bvalid_q;
    assign s_axi.arready = !rst && !rvalid_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    assign aw_hs = s_axi.awvalid && s_axi.awready;
    assign w_hs  = s_axi.wvalid && s_axi.wready;
    assign ar_hs = s_axi.arvalid && s_axi.arready;
    assign b_hs  = bvalid_q && s_axi.bready;
    assign r_hs  = rvalid_q && s_axi.rready;

    assign unused_addr_lsbs = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    // A beat arriving this cycle counts as held, so the commit needs no extra cycle
    assign wa_idx  = aw_held ? aw_idx : s_axi.awaddr[ADDR_W-1:2];
    assign wd_data = w_held ? w_data : s_axi.wdata;
    assign wd_strb = w_held ? w_strb : s_axi.wstrb;
    assign commit  = (aw_held || aw_hs) && (w_held || w_hs) && !bvalid_q;

    assign wa_map    = wa_idx < IDX_ID;
    assign wr_ctrl   = commit && (wa_idx == IDX_CTRL);
    assign wr_status = commit && (wa_idx == IDX_STATUS);
    assign start_req = wr_ctrl && wd_strb[0] && wd_data[0];
    assign start_go  = start_req && !core_busy;
    assign start_err = start_req && core_busy;
    assign clr_done  = wr_status && wd_strb[0] && wd_data[1];
    assign clr_err   = wr_status && wd_strb[0] && wd_data[2];

    always_comb begin
        wr_cfg = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            wr_cfg[i] = commit && (wa_idx == IDX_W'(i + 2));
        end
    end

    assign rd_idx = s_axi.araddr[ADDR_W-1:2];

    always_comb begin
        rd_cfg_hit = 1'b0;
        rd_cfg_val = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (rd_idx == IDX_W'(i + 2)) begin
                rd_cfg_hit = 1'b1;
                rd_cfg_val = cfg_q[i];
            end
        end
    end

    always_comb begin
        rd_val    = '0;
        rd_slverr = 1'b0;
        unique case (1'b1)
            rd_idx == IDX_CTRL:
                rd_val = {{(DATA_W-2){1'b0}}, irq_en, 1'b0};
            rd_idx == IDX_STATUS:
                rd_val = {{(DATA_W-3){1'b0}}, err_q, done_q, core_busy};
            rd_idx == IDX_ID:
                rd_val = DATA_W'(VERSION);
            rd_cfg_hit:
                rd_val = rd_cfg_val;
            default:
                rd_slverr = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held  <= 1'b0;
            aw_idx   <= '0;
            w_held   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_idx  <= s_axi.awaddr[ADDR_W-1:2];
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s_axi.wdata;
                w_strb <= s_axi.wstrb;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wa_map ? RESP_OKAY : RESP_SLVERR;
            end else if (b_hs) begin
                bvalid_q <= 1'b0;
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
            end
        end
    end

    // Set beats clear when a core event and a W1C land together
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (wr_ctrl && wd_strb[0]) irq_en <= wd_data[1];
            done_q  <= core_done || (done_q && !clr_done);
            err_q   <= start_err || (err_q && !clr_err);
            start_q <= start_go;
            irq_q   <= irq_en && (done_q || err_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (wr_cfg[i]) cfg_q[i] <= merge(cfg_q[i], wd_data, wd_strb);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_val;
            rresp_q  <= rd_slverr ? RESP_SLVERR : RESP_OKAY;
        end else if (r_hs) begin
            rvalid_q <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
        assign cfg_flat[g*DATA_W +: DATA_W] = cfg_q[g];
    end

    assign start_pulse = start_q;
    assign irq         = irq_q;
endmodule
